// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and ASCII constants for the UART command decoder
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_OP  = 2'd1,
    GOT_IDX = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_SET = 2'd0,
    OP_CLR = 2'd1,
    OP_TGL = 2'd2,
    OP_RST = 2'd3
  } op_e;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;

  localparam int RESP_FIFO_DEPTH = 4;

  function automatic logic is_term_char(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/ascii_hex_to_nibble.sv
// rtl/ascii_hex_to_nibble.sv - combinational ASCII hex digit decoder, case-insensitive
module ascii_hex_to_nibble (
  input  logic [7:0] char_in,
  output logic       valid_out,
  output logic [3:0] value_out
);

  always_comb begin
    valid_out = 1'b1;
    value_out = 4'h0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      value_out = char_in[3:0];
    end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                 (char_in >= 8'h61 && char_in <= 8'h66)) begin
      // 'A'/'a' carry 1 in the low nibble, so +9 lands on 10
      value_out = char_in[3:0] + 4'd9;
    end else begin
      valid_out = 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - framed S/C/T/R command decoder with K/E acknowledge toward TX
// Define UART_CMD_ECHO_EN to echo every received character through a 4-entry TX FIFO.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int               N_OUT          = 4,
  parameter int               DATA_BITS      = 8,
  parameter logic [N_OUT-1:0] RESET_VALUE    = {N_OUT{1'b1}},
  parameter int               TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 sysclk_in,
  input  logic                 rst_in,
  input  logic [DATA_BITS-1:0] rx_data_in,
  input  logic                 rx_rdy_in,
  output logic [N_OUT-1:0]     out_q,
  output logic                 cmd_err_out,
  output logic [7:0]           tx_data_out,
  output logic                 tx_valid_out,
  input  logic                 tx_ready_in
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [3:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_OUT-1:0]   out_d;
  logic [N_OUT-1:0]   bit_mask;
  logic               cmd_err_q;
  logic [7:0]         ch;
  logic               hex_valid;
  logic [3:0]         hex_value;
  logic               is_op;
  logic               is_term;
  logic               idx_ok;
  logic               timeout_hit;
  logic               exec_cmd;
  logic               reject_cmd;
  logic               resp_push;
  logic [7:0]         resp_char;

  if (DATA_BITS >= 8) begin : g_wide_char
    assign ch = rx_data_in[7:0];
  end else begin : g_narrow_char
    assign ch = {{(8-DATA_BITS){1'b0}}, rx_data_in};
  end

  ascii_hex_to_nibble u_hex (
    .char_in   (ch),
    .valid_out (hex_valid),
    .value_out (hex_value)
  );

  assign is_op   = (ch == CH_S) || (ch == CH_C) || (ch == CH_T);
  assign is_term = is_term_char(ch);
  assign idx_ok  = hex_valid && ({1'b0, hex_value} < 5'(N_OUT));

  // A character arriving in the expiry cycle wins over the timeout
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) &&
                       !rx_rdy_in && (cnt_q == CNT_MAX);

  always_ff @(posedge sysclk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_rdy_in) begin
      case (state_q)
        IDLE: begin
          if (is_op)              state_d = GOT_OP;
          else if (ch == CH_R)    state_d = GOT_IDX;
          else if (!is_term)      state_d = FLUSH;
        end
        GOT_OP: begin
          if (is_term)            state_d = IDLE;
          else if (idx_ok)        state_d = GOT_IDX;
          else                    state_d = FLUSH;
        end
        GOT_IDX: state_d = is_term ? IDLE : FLUSH;
        FLUSH:   if (is_term) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    exec_cmd   = 1'b0;
    reject_cmd = 1'b0;
    op_d       = op_q;
    idx_d      = idx_q;
    if (rx_rdy_in) begin
      case (state_q)
        IDLE: begin
          if (ch == CH_S)      op_d = OP_SET;
          else if (ch == CH_C) op_d = OP_CLR;
          else if (ch == CH_T) op_d = OP_TGL;
          else if (ch == CH_R) op_d = OP_RST;
        end
        GOT_OP: begin
          if (is_term)     reject_cmd = 1'b1;
          else if (idx_ok) idx_d      = hex_value;
        end
        GOT_IDX: exec_cmd   = is_term;
        FLUSH:   reject_cmd = is_term;
        default: ;
      endcase
    end else if (timeout_hit) begin
      reject_cmd = 1'b1;
    end
  end

  always_comb begin
    bit_mask = N_OUT'(1) << idx_q;
    out_d    = out_q;
    if (exec_cmd) begin
      case (op_q)
        OP_SET:  out_d = out_q | bit_mask;
        OP_CLR:  out_d = out_q & ~bit_mask;
        OP_TGL:  out_d = out_q ^ bit_mask;
        default: out_d = RESET_VALUE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rx_rdy_in || state_q == IDLE) cnt_d = '0;
    else if (TIMEOUT_CYCLES != 0 && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sysclk_in) begin
    if (rst_in) begin
      op_q      <= OP_SET;
      idx_q     <= '0;
      cnt_q     <= '0;
      out_q     <= RESET_VALUE;
      cmd_err_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      cmd_err_q <= reject_cmd;
    end
  end

  assign cmd_err_out = cmd_err_q;
  assign resp_push   = exec_cmd || reject_cmd;
  assign resp_char   = exec_cmd ? CH_K : CH_E;

`ifdef UART_CMD_ECHO_EN
  localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(RESP_FIFO_DEPTH);

  logic [7:0]     fifo_q [RESP_FIFO_DEPTH];
  logic [7:0]     fifo_d [RESP_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Echo is pushed ahead of the response; whichever finds the FIFO full is dropped
  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (count_q != '0 && tx_ready_in) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - (PTR_W+1)'(1);
    end
    if (rx_rdy_in && count_d < FIFO_FULL) begin
      fifo_d[wr_ptr_d] = ch;
      wr_ptr_d         = wr_ptr_d + PTR_W'(1);
      count_d          = count_d + (PTR_W+1)'(1);
    end
    if (resp_push && count_d < FIFO_FULL) begin
      fifo_d[wr_ptr_d] = resp_char;
      wr_ptr_d         = wr_ptr_d + PTR_W'(1);
      count_d          = count_d + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge sysclk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RESP_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tx_data_out  = fifo_q[rd_ptr_q];
  assign tx_valid_out = (count_q != '0);
`else
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       tx_hs;

  // A pending response blocks new ones unless it is handed off this same cycle
  always_comb begin
    tx_hs      = tx_valid_q && tx_ready_in;
    tx_data_d  = tx_data_q;
    tx_valid_d = (tx_valid_q && !tx_hs) || resp_push;
    if (resp_push && (!tx_valid_q || tx_hs)) tx_data_d = resp_char;
  end

  always_ff @(posedge sysclk_in) begin
    if (rst_in) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_out  = tx_data_q;
  assign tx_valid_out = tx_valid_q;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed self-checking bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [3:0] out_bits;
  logic       cmd_err;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int total = 0;
  int bad   = 0;

  uart_cmd_decoder #(
    .N_OUT          (4),
    .DATA_BITS      (8),
    .RESET_VALUE    (4'b1111),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .sysclk_in    (clk),
    .rst_in       (rst),
    .rx_data_in   (rx_data),
    .rx_rdy_in    (rx_rdy),
    .out_q        (out_bits),
    .cmd_err_out  (cmd_err),
    .tx_data_out  (tx_data),
    .tx_valid_out (tx_valid),
    .tx_ready_in  (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge after the character was sampled
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    rx_data = c;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_char(a);
    send_char(b);
    send_char(c);
  endtask

  int first_err;
  logic [7:0] err_data;
  logic       err_valid;
  int hs_count;
  logic [7:0] echo_exp [4];

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_rdy   = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_out", out_bits, 4'b1111);
    check("rst_err", cmd_err, 1'b0);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_data", tx_data, 8'h00);

`ifdef UART_CMD_ECHO_EN
    echo_exp[0] = 8'h53;
    echo_exp[1] = 8'h31;
    echo_exp[2] = 8'h0D;
    echo_exp[3] = 8'h4B;
    tx_ready = 1'b0;
    send3(8'h53, 8'h31, 8'h0D);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("echo_valid%0d", k), tx_valid, 1'b1);
      check($sformatf("echo_byte%0d", k), tx_data, echo_exp[k]);
      @(negedge clk);
    end
    check("echo_drained", tx_valid, 1'b0);
    check("echo_out", out_bits, 4'b1111);
`else
    // Clear all bits so the set test starts from 0000
    send3(8'h43, 8'h30, 8'h0D);
    send3(8'h43, 8'h31, 8'h0D);
    send3(8'h43, 8'h32, 8'h0D);
    send3(8'h43, 8'h33, 8'h0D);
    check("clear_all_out", out_bits, 4'b0000);

    send3(8'h53, 8'h32, 8'h0D);
    check("s2_out", out_bits, 4'b0100);
    check("s2_data", tx_data, 8'h4B);
    check("s2_valid", tx_valid, 1'b1);
    check("s2_err", cmd_err, 1'b0);
    @(negedge clk);
    check("s2_handshake_clears", tx_valid, 1'b0);

    send3(8'h54, 8'h30, 8'h0A);
    check("t0a_out", out_bits, 4'b0101);
    check("t0a_data", tx_data, 8'h4B);
    check("t0a_valid", tx_valid, 1'b1);
    send3(8'h54, 8'h30, 8'h0A);
    check("t0b_out", out_bits, 4'b0100);
    check("t0b_valid", tx_valid, 1'b1);
    send_char(8'h52);
    send_char(8'h0D);
    check("r_out", out_bits, 4'b1111);
    check("r_data", tx_data, 8'h4B);
    check("r_valid", tx_valid, 1'b1);

    send3(8'h53, 8'h39, 8'h0D);
    check("s9_err", cmd_err, 1'b1);
    check("s9_data", tx_data, 8'h45);
    check("s9_out", out_bits, 4'b1111);
    @(negedge clk);
    check("s9_err_pulse_ends", cmd_err, 1'b0);
    send3(8'h58, 8'h59, 8'h5A);
    check("xyz_no_err_before_term", cmd_err, 1'b0);
    send_char(8'h0D);
    check("xyz_err", cmd_err, 1'b1);
    check("xyz_data", tx_data, 8'h45);
    check("xyz_valid", tx_valid, 1'b1);
    check("xyz_out", out_bits, 4'b1111);

    // Half command left to time out
    send_char(8'h43);
    first_err = 0;
    err_data  = 8'h00;
    err_valid = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (cmd_err && first_err == 0) begin
        first_err = i;
        err_data  = tx_data;
        err_valid = tx_valid;
      end
    end
    check("timeout_edge", first_err, 101);
    check("timeout_data", err_data, 8'h45);
    check("timeout_valid", err_valid, 1'b1);
    check("timeout_out", out_bits, 4'b1111);
    send3(8'h43, 8'h31, 8'h0D);
    check("after_timeout_out", out_bits, 4'b1101);
    check("after_timeout_data", tx_data, 8'h4B);

    // Character lands exactly in the expiry cycle
    send_char(8'h43);
    repeat (99) @(negedge clk);
    send_char(8'h33);
    check("expiry_race_no_err", cmd_err, 1'b0);
    send_char(8'h0D);
    check("expiry_race_err", cmd_err, 1'b0);
    check("expiry_race_out", out_bits, 4'b0101);
    check("expiry_race_data", tx_data, 8'h4B);
    @(negedge clk);

    tx_ready = 1'b0;
    send3(8'h53, 8'h31, 8'h0D);
    check("bp1_out", out_bits, 4'b0111);
    check("bp1_data", tx_data, 8'h4B);
    check("bp1_valid", tx_valid, 1'b1);
    send3(8'h54, 8'h31, 8'h0D);
    check("bp2_out", out_bits, 4'b0101);
    check("bp2_valid", tx_valid, 1'b1);
    check("bp2_data", tx_data, 8'h4B);
    tx_ready = 1'b1;
    hs_count = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_valid && tx_ready) hs_count++;
      @(negedge clk);
    end
    check("bp_handshakes", hs_count, 1);

    // Reset mid-command drops both the partial command and the pending response
    tx_ready = 1'b0;
    send_char(8'h52);
    send_char(8'h0D);
    check("pre_rst_valid", tx_valid, 1'b1);
    send_char(8'h54);
    send_char(8'h30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", out_bits, 4'b1111);
    check("midrst_valid", tx_valid, 1'b0);
    check("midrst_data", tx_data, 8'h00);
    check("midrst_err", cmd_err, 1'b0);
    send_char(8'h0D);
    check("midrst_term_err", cmd_err, 1'b0);
    check("midrst_term_valid", tx_valid, 1'b0);
    check("midrst_term_out", out_bits, 4'b1111);
    tx_ready = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
